// File: rtl/branch_redirect_ctrl.sv
// MEM-stage branch resolution -> registered one-cycle PC redirect plus pipeline flush.
// A redirect opens a shadow window where wrong-path is_jump decisions are blanked.
module branch_redirect_ctrl #(
  parameter int ADDR_W        = 32,
  parameter int SHADOW_CYCLES = 3,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              is_jump,
  input  logic [ADDR_W-1:0] mem_target,
  input  logic              freeze,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_IF_ID,
  output logic              flush_ID_EX,
  output logic              flush_EX_MEM,
  output logic              busy,
  output logic [CNT_W-1:0]  taken_count
);

  localparam int SC_W = $clog2(SHADOW_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PENDING, SHADOW} state_t;

  state_t            state, state_nxt;
  logic [SC_W-1:0]   shadow_cnt, shadow_cnt_nxt;
  logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
  logic              take, fire;
  logic [ADDR_W-1:0] fire_pc;

  assign take = mem_valid & is_jump;

  always_comb begin
    state_nxt      = state;
    shadow_cnt_nxt = shadow_cnt;
    pend_pc_nxt    = pend_pc;
    fire           = 1'b0;
    fire_pc        = pend_pc;
    case (state)
      IDLE: begin
        if (take) begin
          if (freeze) begin
            pend_pc_nxt = mem_target;
            state_nxt   = PENDING;
          end else begin
            fire    = 1'b1;
            fire_pc = mem_target;
          end
        end
      end
      // MEM is frozen on the same instruction, so a repeated take is not a new branch
      PENDING: if (!freeze) fire = 1'b1;
      SHADOW: begin
        if (shadow_cnt <= SC_W'(1)) state_nxt = IDLE;
        else                        shadow_cnt_nxt = shadow_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // The pulse cycle itself is the first shadow cycle
    if (fire) begin
      state_nxt      = SHADOW;
      shadow_cnt_nxt = SC_W'(SHADOW_CYCLES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      shadow_cnt     <= '0;
      pend_pc        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_IF_ID    <= 1'b0;
      flush_ID_EX    <= 1'b0;
      flush_EX_MEM   <= 1'b0;
      taken_count    <= '0;
    end else begin
      state          <= state_nxt;
      shadow_cnt     <= shadow_cnt_nxt;
      pend_pc        <= pend_pc_nxt;
      redirect_valid <= fire;
      flush_IF_ID    <= fire;
      flush_ID_EX    <= fire;
      flush_EX_MEM   <= fire;
      if (fire) redirect_pc <= fire_pc;
      if (fire && (taken_count != {CNT_W{1'b1}})) taken_count <= taken_count + 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: cycle model of redirect/shadow/pending rules
// compared every cycle, plus directed literal expectations.
module tb_branch_redirect_ctrl;
  localparam int SH = 3;

  logic        clk, rst_n;
  logic        mem_valid, is_jump, freeze;
  logic [31:0] mem_target;

  logic        rv_a, fi_a, fd_a, fe_a, busy_a;
  logic [31:0] pc_a;
  logic [15:0] cnt_a;
  logic        rv_b, fi_b, fd_b, fe_b, busy_b;
  logic [31:0] pc_b;
  logic [1:0]  cnt_b;

  branch_redirect_ctrl #(.ADDR_W(32), .SHADOW_CYCLES(SH), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .is_jump(is_jump),
    .mem_target(mem_target), .freeze(freeze), .redirect_valid(rv_a),
    .redirect_pc(pc_a), .flush_IF_ID(fi_a), .flush_ID_EX(fd_a),
    .flush_EX_MEM(fe_a), .busy(busy_a), .taken_count(cnt_a));

  branch_redirect_ctrl #(.ADDR_W(32), .SHADOW_CYCLES(SH), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .is_jump(is_jump),
    .mem_target(mem_target), .freeze(freeze), .redirect_valid(rv_b),
    .redirect_pc(pc_b), .flush_IF_ID(fi_b), .flush_ID_EX(fd_b),
    .flush_EX_MEM(fe_b), .busy(busy_b), .taken_count(cnt_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: edge index m_n; a redirect decided at edge T blanks edges T+1..T+SH.
  int          m_n = 0;
  int          m_shadow_end = -1;
  int          m_cnt = 0;
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_tgt = '0;
  logic        m_rv = 1'b0;
  logic [31:0] m_pc = '0;
  logic        m_open, m_fire;

  always_comb begin
    m_open = m_n > m_shadow_end;
    m_fire = rst_n && m_open && !freeze && (m_pend || (mem_valid && is_jump));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= 0; m_shadow_end <= -1; m_cnt <= 0;
      m_pend <= 1'b0; m_pend_tgt <= '0; m_rv <= 1'b0; m_pc <= '0;
    end else begin
      m_n  <= m_n + 1;
      m_rv <= m_fire;
      if (m_fire) begin
        m_pc         <= m_pend ? m_pend_tgt : mem_target;
        m_cnt        <= m_cnt + 1;
        m_shadow_end <= m_n + SH;
        m_pend       <= 1'b0;
      end else if (m_open && !m_pend && mem_valid && is_jump && freeze) begin
        m_pend     <= 1'b1;
        m_pend_tgt <= mem_target;
      end
    end
  end

  always @(negedge clk) begin
    chk("redirect_valid", rv_a, m_rv);
    chk("flushes", {fi_a, fd_a, fe_a}, {3{m_rv}});
    chk("busy", busy_a, m_pend || (m_n <= m_shadow_end));
    chk("taken_count", cnt_a, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("taken_count_w2", cnt_b, (m_cnt > 3) ? 3 : m_cnt);
    chk("redirect_valid_w2", rv_b, m_rv);
    if (m_rv) chk("redirect_pc", pc_a, m_pc);
  end

  task automatic drive(input logic v, input logic j, input logic [31:0] t, input logic f);
    @(negedge clk);
    mem_valid = v; is_jump = j; mem_target = t; freeze = f;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy_a && k < 20) begin drive(0, 0, 0, 0); k++; end
    if (busy_a) chk("idle_timeout", busy_a, 1'b0);
    drive(0, 0, 0, 0);
  endtask

  logic [1:0] exp_b [5];

  initial begin
    exp_b[0] = 2'd1; exp_b[1] = 2'd2; exp_b[2] = 2'd3; exp_b[3] = 2'd3; exp_b[4] = 2'd3;
    rst_n = 1'b0; mem_valid = 0; is_jump = 0; mem_target = 0; freeze = 0;
    repeat (2) @(negedge clk);
    chk("reset_rv", rv_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_cnt", cnt_a, 16'd0);
    rst_n = 1'b1;

    // Unfrozen take -> pulse next cycle
    drive(1, 1, 32'h0040_0100, 0);
    drive(0, 0, 0, 0);
    chk("t2_rv", rv_a, 1'b1);
    chk("t2_pc", pc_a, 32'h0040_0100);
    chk("t2_flush", {fi_a, fd_a, fe_a}, 3'b111);
    chk("t2_cnt", cnt_a, 16'd1);
    drive(0, 0, 0, 0);
    chk("t2_one_cycle", rv_a, 1'b0);
    wait_idle();

    // Async reset during a pulse cycle
    drive(1, 1, 32'hAAAA_0000, 0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t1_rv", rv_a, 1'b0);
    chk("t1_flush", {fi_a, fd_a, fe_a}, 3'b000);
    chk("t1_busy", busy_a, 1'b0);
    chk("t1_cnt", cnt_a, 16'd0);
    drive(0, 0, 0, 0);
    rst_n = 1'b1;

    // Frozen take -> pending, released by freeze drop; freeze in pulse cycle
    repeat (4) drive(1, 1, 32'h1234_5678, 1);
    chk("t3_pend_busy", busy_a, 1'b1);
    chk("t3_no_pulse", rv_a, 1'b0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("t3_rv", rv_a, 1'b1);
    chk("t3_pc", pc_a, 32'h1234_5678);
    drive(0, 0, 0, 0);
    chk("t3_one_cycle", rv_a, 1'b0);
    wait_idle();

    // mem_valid low is not a take
    drive(0, 1, 32'h0000_0BAD, 0);
    drive(0, 0, 0, 0);
    chk("nv_no_pulse", rv_a, 1'b0);

    // Takes inside the shadow window are ignored
    drive(1, 1, 32'h100, 0);
    drive(1, 1, 32'h200, 0);
    chk("t4_rv", rv_a, 1'b1);
    chk("t4_pc", pc_a, 32'h100);
    drive(1, 1, 32'h300, 0);
    chk("t4_ign1", rv_a, 1'b0);
    drive(1, 1, 32'h400, 0);
    chk("t4_ign2", rv_a, 1'b0);
    chk("t4_busy", busy_a, 1'b1);
    drive(1, 1, 32'h500, 0);
    chk("t4_idle", busy_a, 1'b0);
    drive(0, 0, 0, 0);
    chk("t4_new_rv", rv_a, 1'b1);
    chk("t4_new_pc", pc_a, 32'h500);
    wait_idle();

    // Reset while pending drops the held target
    drive(1, 1, 32'hDEAD_0000, 1);
    drive(0, 0, 0, 1);
    chk("t5_busy", busy_a, 1'b1);
    #3 rst_n = 1'b0;
    #1 chk("t5_rst_busy", busy_a, 1'b0);
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) begin
      drive(0, 0, 0, 0);
      chk("t5_no_pulse", rv_a, 1'b0);
    end

    // Saturating count at CNT_W=2
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'h1000 + 32'(i), 0);
      drive(0, 0, 0, 0);
      chk("t6_cnt_w2", cnt_b, exp_b[i]);
      chk("t6_cnt_w16", cnt_a, 16'(i + 1));
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
